// File: rtl/board_attack_engine.sv
// Chess attack-map engine: accepts one board per handshake, scans LANES source squares per cycle into per-colour
// attack maps, then derives check/illegal flags. Popcount outputs are built only with BOARD_ATTACK_POPCOUNT_EN defined.
module board_attack_engine #(
  parameter int PIECE_WIDTH = 4,
  parameter int SIDE_WIDTH  = 1,
  parameter int BOARD_WIDTH = 64 * PIECE_WIDTH,
  parameter int LANES       = 4,
  parameter int TAG_WIDTH   = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [BOARD_WIDTH-1:0] board,
  input  logic [TAG_WIDTH-1:0]   board_tag,
  input  logic                   white_to_move,
  input  logic                   board_valid,
  output logic                   board_ready,
  output logic [63:0]            white_is_attacking,
  output logic [63:0]            black_is_attacking,
  output logic                   white_in_check,
  output logic                   black_in_check,
  output logic                   illegal,
  output logic [6:0]             white_attack_count,
  output logic [6:0]             black_attack_count,
  output logic [TAG_WIDTH-1:0]   result_tag,
  output logic                   result_valid,
  input  logic                   result_ready
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_CHECK, S_DONE} state_e;
  typedef enum logic [2:0] {
    P_NONE, P_PAWN, P_KNIGHT, P_BISHOP, P_ROOK, P_QUEEN, P_KING, P_RSVD
  } piece_e;

  function automatic logic on_board(input int f, input int r);
    return (f >= 0) && (f < 8) && (r >= 0) && (r < 8);
  endfunction

  function automatic logic [5:0] sq_of(input int f, input int r);
    return 6'((r * 8) + f);
  endfunction

  function automatic logic side_of(input logic [PIECE_WIDTH-1:0] pc);
    logic [SIDE_WIDTH-1:0] s;
    s = pc[PIECE_WIDTH-1 -: SIDE_WIDTH];
    return s[0];
  endfunction

  // Directions 0..3 are orthogonal, 4..7 diagonal; rooks use the first half, bishops the second.
  function automatic void ray_dir(input int d, output int df, output int dr);
    case (d)
      0:       begin df =  1; dr =  0; end
      1:       begin df = -1; dr =  0; end
      2:       begin df =  0; dr =  1; end
      3:       begin df =  0; dr = -1; end
      4:       begin df =  1; dr =  1; end
      5:       begin df = -1; dr =  1; end
      6:       begin df =  1; dr = -1; end
      default: begin df = -1; dr = -1; end
    endcase
  endfunction

  function automatic void knight_dir(input int d, output int df, output int dr);
    case (d)
      0:       begin df =  1; dr =  2; end
      1:       begin df =  2; dr =  1; end
      2:       begin df =  2; dr = -1; end
      3:       begin df =  1; dr = -2; end
      4:       begin df = -1; dr = -2; end
      5:       begin df = -2; dr = -1; end
      6:       begin df = -2; dr =  1; end
      default: begin df = -1; dr =  2; end
    endcase
  endfunction

  function automatic logic [63:0] piece_attacks(input logic [63:0] occ, input logic [5:0] sq,
                                                input piece_e ptype, input logic is_black);
    logic [63:0] m;
    logic [5:0]  t;
    logic        blocked;
    int          f, r, df, dr, nf, nr;
    m  = '0;
    f  = int'(sq[2:0]);
    r  = int'(sq[5:3]);
    df = 0;
    dr = 0;
    case (ptype)
      P_PAWN: begin
        dr = is_black ? -1 : 1;
        for (int k = 0; k < 2; k++) begin
          nf = f + ((k == 0) ? -1 : 1);
          nr = r + dr;
          if (on_board(nf, nr)) m[sq_of(nf, nr)] = 1'b1;
        end
      end
      P_KNIGHT, P_KING: begin
        for (int d = 0; d < 8; d++) begin
          if (ptype == P_KNIGHT) knight_dir(d, df, dr);
          else                   ray_dir(d, df, dr);
          if (on_board(f + df, r + dr)) m[sq_of(f + df, r + dr)] = 1'b1;
        end
      end
      P_BISHOP, P_ROOK, P_QUEEN: begin
        for (int d = 0; d < 8; d++) begin
          if ((d < 4 && ptype != P_BISHOP) || (d >= 4 && ptype != P_ROOK)) begin
            ray_dir(d, df, dr);
            blocked = 1'b0;
            for (int step = 1; step < 8; step++) begin
              nf = f + df * step;
              nr = r + dr * step;
              if (!blocked && on_board(nf, nr)) begin
                t       = sq_of(nf, nr);
                m[t]    = 1'b1;
                blocked = occ[t];
              end
            end
          end
        end
      end
      default: ;
    endcase
    return m;
  endfunction

  state_e                 state_q, state_d;
  logic [5:0]             idx_q, idx_d;
  logic [BOARD_WIDTH-1:0] board_q, board_d;
  logic [TAG_WIDTH-1:0]   tag_q, tag_d;
  logic                   wtm_q, wtm_d;
  logic [63:0]            wmap_q, wmap_d, bmap_q, bmap_d;
  logic                   wchk_q, wchk_d, bchk_q, bchk_d, ill_q, ill_d;
`ifdef BOARD_ATTACK_POPCOUNT_EN
  logic [6:0]             wcnt_q, wcnt_d, bcnt_q, bcnt_d;
`endif

  logic [PIECE_WIDTH-1:0] piece_arr [64];
  logic [63:0]            occ, wking, bking, w_add, b_add;

  always_comb begin
    occ   = '0;
    wking = '0;
    bking = '0;
    for (int i = 0; i < 64; i++) begin
      piece_arr[i] = board_q[i*PIECE_WIDTH +: PIECE_WIDTH];
      occ[i]       = piece_arr[i][2:0] != 3'(P_NONE);
      wking[i]     = (piece_arr[i][2:0] == 3'(P_KING)) && !side_of(piece_arr[i]);
      bking[i]     = (piece_arr[i][2:0] == 3'(P_KING)) &&  side_of(piece_arr[i]);
    end
  end

  always_comb begin
    w_add = '0;
    b_add = '0;
    for (int l = 0; l < LANES; l++) begin
      logic [5:0]             src;
      logic [PIECE_WIDTH-1:0] pc;
      logic [63:0]            atk;
      src = idx_q + 6'(l);
      pc  = piece_arr[src];
      atk = piece_attacks(occ, src, piece_e'(pc[2:0]), side_of(pc));
      if (side_of(pc)) b_add = b_add | atk;
      else             w_add = w_add | atk;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    board_d      = board_q;
    tag_d        = tag_q;
    wtm_d        = wtm_q;
    wmap_d       = wmap_q;
    bmap_d       = bmap_q;
    wchk_d       = wchk_q;
    bchk_d       = bchk_q;
    ill_d        = ill_q;
    board_ready  = 1'b0;
    result_valid = 1'b0;
`ifdef BOARD_ATTACK_POPCOUNT_EN
    wcnt_d       = wcnt_q;
    bcnt_d       = bcnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        board_ready = 1'b1;
        if (board_valid) begin
          board_d = board;
          tag_d   = board_tag;
          wtm_d   = white_to_move;
          wmap_d  = '0;
          bmap_d  = '0;
          wchk_d  = 1'b0;
          bchk_d  = 1'b0;
          ill_d   = 1'b0;
          idx_d   = '0;
          state_d = S_SCAN;
`ifdef BOARD_ATTACK_POPCOUNT_EN
          wcnt_d  = '0;
          bcnt_d  = '0;
`endif
        end
      end
      S_SCAN: begin
        wmap_d = wmap_q | w_add;
        bmap_d = bmap_q | b_add;
        idx_d  = idx_q + 6'(LANES);
        if (idx_q == 6'(64 - LANES)) state_d = S_CHECK;
      end
      S_CHECK: begin
        // NOTE: blocking '=' in combinational logic, so ill_d below sees the freshly computed check flags.
        wchk_d  = |(bmap_q & wking);
        bchk_d  = |(wmap_q & bking);
        ill_d   = wtm_q ? bchk_d : wchk_d;
        state_d = S_DONE;
`ifdef BOARD_ATTACK_POPCOUNT_EN
        wcnt_d  = 7'($countones(wmap_q));
        bcnt_d  = 7'($countones(bmap_q));
`endif
      end
      S_DONE: begin
        result_valid = 1'b1;
        if (result_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: non-blocking '<=' for every register so all state updates together on the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      tag_q   <= '0;
      wtm_q   <= 1'b0;
      wmap_q  <= '0;
      bmap_q  <= '0;
      wchk_q  <= 1'b0;
      bchk_q  <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tag_q   <= tag_d;
      wtm_q   <= wtm_d;
      wmap_q  <= wmap_d;
      bmap_q  <= bmap_d;
      wchk_q  <= wchk_d;
      bchk_q  <= bchk_d;
      ill_q   <= ill_d;
    end
  end

  // NOTE: the board copy is pure data, only read after a fresh load, so it carries no reset.
  always_ff @(posedge clk) begin
    board_q <= board_d;
  end

`ifdef BOARD_ATTACK_POPCOUNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      wcnt_q <= '0;
      bcnt_q <= '0;
    end else begin
      wcnt_q <= wcnt_d;
      bcnt_q <= bcnt_d;
    end
  end
  assign white_attack_count = wcnt_q;
  assign black_attack_count = bcnt_q;
`else
  assign white_attack_count = 7'd0;
  assign black_attack_count = 7'd0;
`endif

  assign white_is_attacking = wmap_q;
  assign black_is_attacking = bmap_q;
  assign white_in_check     = wchk_q;
  assign black_in_check     = bchk_q;
  assign illegal            = ill_q;
  assign result_tag         = tag_q;

endmodule

// File: tb/tb_board_attack_engine.sv
// Self-checking bench for board_attack_engine: directed table, hand-written handshake/reset sequences,
// random boards against a geometric reference model, and LANES=1/64 latency comparison.
module tb_board_attack_engine;

  logic         clk = 1'b0;
  logic         reset;
  logic [255:0] board;
  logic [7:0]   board_tag;
  logic         white_to_move;
  logic         board_valid;
  logic         board_ready;
  logic [63:0]  white_is_attacking, black_is_attacking;
  logic         white_in_check, black_in_check, illegal;
  logic [6:0]   white_attack_count, black_attack_count;
  logic [7:0]   result_tag;
  logic         result_valid;
  logic         result_ready;

  logic         bv1, br1, rv1, wc1, bc1, il1;
  logic [63:0]  wm1, bm1;
  logic [6:0]   wn1, bn1;
  logic [7:0]   rt1;
  logic         bv64, br64, rv64, wc64, bc64, il64;
  logic [63:0]  wm64, bm64;
  logic [6:0]   wn64, bn64;
  logic [7:0]   rt64;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  board_attack_engine #(.LANES(4)) dut (
    .clk(clk), .reset(reset), .board(board), .board_tag(board_tag), .white_to_move(white_to_move),
    .board_valid(board_valid), .board_ready(board_ready),
    .white_is_attacking(white_is_attacking), .black_is_attacking(black_is_attacking),
    .white_in_check(white_in_check), .black_in_check(black_in_check), .illegal(illegal),
    .white_attack_count(white_attack_count), .black_attack_count(black_attack_count),
    .result_tag(result_tag), .result_valid(result_valid), .result_ready(result_ready)
  );

  board_attack_engine #(.LANES(1)) dut_l1 (
    .clk(clk), .reset(reset), .board(board), .board_tag(board_tag), .white_to_move(white_to_move),
    .board_valid(bv1), .board_ready(br1), .white_is_attacking(wm1), .black_is_attacking(bm1),
    .white_in_check(wc1), .black_in_check(bc1), .illegal(il1),
    .white_attack_count(wn1), .black_attack_count(bn1),
    .result_tag(rt1), .result_valid(rv1), .result_ready(1'b1)
  );

  board_attack_engine #(.LANES(64)) dut_l64 (
    .clk(clk), .reset(reset), .board(board), .board_tag(board_tag), .white_to_move(white_to_move),
    .board_valid(bv64), .board_ready(br64), .white_is_attacking(wm64), .black_is_attacking(bm64),
    .white_in_check(wc64), .black_in_check(bc64), .illegal(il64),
    .white_attack_count(wn64), .black_attack_count(bn64),
    .result_tag(rt64), .result_valid(rv64), .result_ready(1'b1)
  );

  typedef struct {
    logic [255:0] brd;
    logic [7:0]   tag;
    logic         wtm;
    logic [63:0]  wmap;
    logic [63:0]  bmap;
    logic         wchk;
    logic         bchk;
    logic         ill;
  } vec_t;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic int iabs(input int x);
    return (x < 0) ? -x : x;
  endfunction

  function automatic int sgn(input int x);
    return (x > 0) ? 1 : ((x < 0) ? -1 : 0);
  endfunction

  function automatic logic occupied(input logic [255:0] b, input int s);
    logic [3:0] p;
    p = b[s*4 +: 4];
    return p[2:0] != 3'd0;
  endfunction

  // Reference: for every piece and every other square, decide by geometry whether the square is hit.
  function automatic void model(input logic [255:0] b, output logic [63:0] wm, output logic [63:0] bm);
    logic [3:0] p;
    int df, dr, n, k, sf, sr, tf, tr;
    logic hit, line;
    wm = '0;
    bm = '0;
    for (int s = 0; s < 64; s++) begin
      p = b[s*4 +: 4];
      for (int d = 0; d < 64; d++) begin
        df = (d % 8) - (s % 8);
        dr = (d / 8) - (s / 8);
        hit = 1'b0;
        if (d != s) begin
          case (p[2:0])
            3'd1: hit = (iabs(df) == 1) && (dr == (p[3] ? -1 : 1));
            3'd2: hit = (iabs(df) * iabs(dr)) == 2;
            3'd6: hit = (iabs(df) <= 1) && (iabs(dr) <= 1);
            3'd3, 3'd4, 3'd5: begin
              line = ((p[2:0] != 3'd3) && (df == 0 || dr == 0)) ||
                     ((p[2:0] != 3'd4) && (iabs(df) == iabs(dr)));
              if (line) begin
                hit = 1'b1;
                n = (iabs(df) > iabs(dr)) ? iabs(df) : iabs(dr);
                for (k = 1; k < n; k++) begin
                  sf = (s % 8) + k * sgn(df);
                  sr = (s / 8) + k * sgn(dr);
                  tf = sr * 8 + sf;
                  tr = tf;
                  if (occupied(b, tr)) hit = 1'b0;
                end
              end
            end
            default: hit = 1'b0;
          endcase
        end
        if (hit) begin
          if (p[3]) bm[d] = 1'b1;
          else      wm[d] = 1'b1;
        end
      end
    end
  endfunction

  function automatic vec_t make_vec(input logic [255:0] b, input logic [7:0] tag, input logic wtm);
    vec_t v;
    logic [63:0] wk, bk;
    logic [3:0]  p;
    v.brd = b;
    v.tag = tag;
    v.wtm = wtm;
    model(b, v.wmap, v.bmap);
    wk = '0;
    bk = '0;
    for (int s = 0; s < 64; s++) begin
      p = b[s*4 +: 4];
      if (p[2:0] == 3'd6) begin
        if (p[3]) bk[s] = 1'b1;
        else      wk[s] = 1'b1;
      end
    end
    v.wchk = |(v.bmap & wk);
    v.bchk = |(v.wmap & bk);
    v.ill  = wtm ? v.bchk : v.wchk;
    return v;
  endfunction

  function automatic logic [255:0] start_pos();
    logic [255:0] b;
    logic [2:0]   back [8];
    back = '{3'd4, 3'd2, 3'd3, 3'd5, 3'd6, 3'd3, 3'd2, 3'd4};
    b = '0;
    for (int f = 0; f < 8; f++) begin
      b[f*4 +: 4]        = {1'b0, back[f]};
      b[(8 + f)*4 +: 4]  = 4'b0001;
      b[(48 + f)*4 +: 4] = 4'b1001;
      b[(56 + f)*4 +: 4] = {1'b1, back[f]};
    end
    return b;
  endfunction

  function automatic logic [6:0] exp_count(input logic [63:0] m);
`ifdef BOARD_ATTACK_POPCOUNT_EN
    return 7'($countones(m));
`else
    return (m == m) ? 7'd0 : 7'd1;
`endif
  endfunction

  task automatic wait_result(input string nm, output int n);
    n = 1;
    while (!result_valid && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!result_valid) begin
      n_vec++;
      n_miss++;
      $display("FAIL %s_timeout: result_valid never rose within %0d cycles", nm, n);
    end
  endtask

  task automatic check_result(input string nm, input vec_t v);
    check({nm, "_wmap"}, white_is_attacking, v.wmap);
    check({nm, "_bmap"}, black_is_attacking, v.bmap);
    check({nm, "_wchk"}, 64'(white_in_check), 64'(v.wchk));
    check({nm, "_bchk"}, 64'(black_in_check), 64'(v.bchk));
    check({nm, "_illegal"}, 64'(illegal), 64'(v.ill));
    check({nm, "_tag"}, 64'(result_tag), 64'(v.tag));
    check({nm, "_wcnt"}, 64'(white_attack_count), 64'(exp_count(v.wmap)));
    check({nm, "_bcnt"}, 64'(black_attack_count), 64'(exp_count(v.bmap)));
  endtask

  task automatic run_board(input string nm, input vec_t v);
    int n;
    check({nm, "_ready"}, 64'(board_ready), 64'd1);
    board         = v.brd;
    board_tag     = v.tag;
    white_to_move = v.wtm;
    board_valid   = 1'b1;
    @(posedge clk);
    #1;
    board_valid   = 1'b0;
    board         = ~v.brd;
    board_tag     = ~v.tag;
    white_to_move = ~v.wtm;
    wait_result(nm, n);
    check({nm, "_latency"}, 64'(n), 64'd18);
    check_result(nm, v);
    result_ready = 1'b1;
    @(posedge clk);
    #1;
    result_ready = 1'b0;
  endtask

  vec_t         vt [4];
  vec_t         va, vb, vr;
  logic [255:0] b;
  int           n, lat1, lat64;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; board = '0; board_tag = '0; white_to_move = 1'b0;
    board_valid = 1'b0; result_ready = 1'b0; bv1 = 1'b0; bv64 = 1'b0;

    // Directed table: start position, rook check, pawn/rook edge case, knight check with white to move.
    vt[0] = make_vec(start_pos(), 8'h01, 1'b1);
    vt[0].wmap = 64'h0000_0000_00FF_FF7E;
    vt[0].bmap = 64'h7EFF_FF00_0000_0000;
    vt[0].wchk = 1'b0; vt[0].bchk = 1'b0; vt[0].ill = 1'b0;

    b = '0; b[4*4 +: 4] = 4'b0110; b[60*4 +: 4] = 4'b1110; b[36*4 +: 4] = 4'b1100;
    vt[1] = make_vec(b, 8'h5A, 1'b0);
    vt[1].wchk = 1'b1; vt[1].bchk = 1'b0; vt[1].ill = 1'b1;

    b = '0; b[0*4 +: 4] = 4'b0100; b[24*4 +: 4] = 4'b0001; b[15*4 +: 4] = 4'b0001;
    vt[2] = make_vec(b, 8'hC3, 1'b1);
    vt[2].wmap = 64'h0000_0002_0141_01FE;
    vt[2].bmap = 64'h0;
    vt[2].wchk = 1'b0; vt[2].bchk = 1'b0; vt[2].ill = 1'b0;

    b = '0; b[0*4 +: 4] = 4'b0110; b[60*4 +: 4] = 4'b1110; b[43*4 +: 4] = 4'b0010;
    vt[3] = make_vec(b, 8'h77, 1'b1);
    vt[3].wchk = 1'b0; vt[3].bchk = 1'b1; vt[3].ill = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("reset_board_ready", 64'(board_ready), 64'd1);
    check("reset_result_valid", 64'(result_valid), 64'd0);
    check("reset_wmap", white_is_attacking, 64'd0);
    check("reset_bmap", black_is_attacking, 64'd0);
    check("reset_flags", {61'd0, white_in_check, black_in_check, illegal}, 64'd0);
    check("reset_tag", 64'(result_tag), 64'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 4; i++) run_board($sformatf("table%0d", i), vt[i]);

    // Backpressure: result held 10 cycles while a second board waits on the input.
    va = vt[0]; va.tag = 8'h11;
    vb = vt[2]; vb.tag = 8'h22;
    board = va.brd; board_tag = va.tag; white_to_move = va.wtm; board_valid = 1'b1;
    @(posedge clk);
    #1;
    board = vb.brd; board_tag = vb.tag; white_to_move = vb.wtm;
    wait_result("bp_first", n);
    for (int c = 0; c < 10; c++) begin
      check("bp_board_ready", 64'(board_ready), 64'd0);
      check("bp_valid_held", 64'(result_valid), 64'd1);
      check("bp_wmap_stable", white_is_attacking, va.wmap);
      check("bp_tag_stable", 64'(result_tag), 64'(va.tag));
      @(posedge clk);
      #1;
    end
    result_ready = 1'b1;
    @(posedge clk);
    #1;
    result_ready = 1'b0;
    check("bp_idle_ready", 64'(board_ready), 64'd1);
    check("bp_idle_valid", 64'(result_valid), 64'd0);
    @(posedge clk);
    #1;
    board_valid = 1'b0;
    wait_result("bp_second", n);
    check("bp_second_latency", 64'(n), 64'd18);
    check_result("bp_second", vb);
    result_ready = 1'b1;
    @(posedge clk);
    #1;
    result_ready = 1'b0;

    // Reset pulse in the middle of a scan.
    board = vt[1].brd; board_tag = vt[1].tag; white_to_move = vt[1].wtm; board_valid = 1'b1;
    @(posedge clk);
    #1;
    board_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("midreset_ready", 64'(board_ready), 64'd1);
    check("midreset_valid", 64'(result_valid), 64'd0);
    check("midreset_wmap", white_is_attacking, 64'd0);
    check("midreset_bmap", black_is_attacking, 64'd0);
    check("midreset_tag", 64'(result_tag), 64'd0);
    run_board("after_reset", vt[3]);

    // Random boards against the reference model.
    for (int r = 0; r < 30; r++) begin
      b = '0;
      for (int s = 0; s < 64; s++)
        if ($urandom_range(0, 99) < 25) b[s*4 +: 4] = 4'($urandom_range(1, 15));
      if ($urandom_range(0, 9) < 7) b[$urandom_range(0, 63)*4 +: 4] = 4'b0110;
      if ($urandom_range(0, 9) < 7) b[$urandom_range(0, 63)*4 +: 4] = 4'b1110;
      vr = make_vec(b, 8'($urandom), 1'($urandom));
      run_board($sformatf("rand%0d", r), vr);
    end

    // LANES=1 and LANES=64 builds on the start position.
    board = start_pos(); board_tag = 8'h3C; white_to_move = 1'b1;
    bv1 = 1'b1; bv64 = 1'b1;
    @(posedge clk);
    #1;
    bv1 = 1'b0; bv64 = 1'b0;
    lat1 = 0; lat64 = 0;
    for (int c = 1; c < 120; c++) begin
      if (rv1 && lat1 == 0) lat1 = c;
      if (rv64 && lat64 == 0) lat64 = c;
      @(posedge clk);
      #1;
    end
    check("l1_latency", 64'(lat1), 64'd66);
    check("l64_latency", 64'(lat64), 64'd3);
    check("l1_wmap", wm1, 64'h0000_0000_00FF_FF7E);
    check("l1_bmap", bm1, 64'h7EFF_FF00_0000_0000);
    check("l64_wmap", wm64, 64'h0000_0000_00FF_FF7E);
    check("l64_bmap", bm64, 64'h7EFF_FF00_0000_0000);
    check("l64_tag", 64'(rt64), 64'h3C);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
